// File: rtl/rtc_write_sequencer.sv
// RTC write sequencer: streams NUM_REGS bytes to the RTC
// over a muxed address/data bus, then pulses band_fin.
module rtc_write_sequencer #(
  parameter int        NUM_REGS   = 6,
  parameter logic [7:0] FIRST_ADDR = 8'h21,
  parameter int        T_PULSE    = 4,
  parameter int        T_GAP      = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en_progra,
  input  logic [8*NUM_REGS-1:0]   reg_data,
  output logic [7:0]              ad_out,
  output logic                    ad_oe,
  output logic                    a_d,
  output logic                    cs_n,
  output logic                    wr_n,
  output logic                    rd_n,
  output logic                    busy,
  output logic                    band_fin
);

  localparam int TMAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_A_PULSE, S_A_GAP,
    S_D_PULSE, S_D_GAP, S_DONE, S_WAIT_LOW
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [8*NUM_REGS-1:0]   buf_q;

  logic [CW-1:0] cnt_inc;
  logic          pulse_end;
  logic          gap_end;
  logic          last_byte;

  assign cnt_inc   = CW'(cnt_q + 1'b1);
  assign pulse_end = (cnt_q == CW'(T_PULSE - 1));
  assign gap_end   = (cnt_q == CW'(T_GAP - 1));
  assign last_byte = (idx_q == 4'(NUM_REGS - 1));
  assign rd_n      = 1'b1;

  // State, phase counter, byte index and data snapshot
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (state_d == S_LATCH) buf_q <= reg_data;
    end
  end

  // Next state: phase timing, byte stepping and abort
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (en_progra) state_d = S_LATCH;
      end
      S_LATCH: begin
        idx_d = '0;
        if (!en_progra) state_d = S_IDLE;
        else            state_d = S_A_PULSE;
      end
      S_A_PULSE: begin
        if (!en_progra)     state_d = S_IDLE;
        else if (pulse_end) state_d = S_A_GAP;
        else                cnt_d   = cnt_inc;
      end
      S_A_GAP: begin
        if (!en_progra)   state_d = S_IDLE;
        else if (gap_end) state_d = S_D_PULSE;
        else              cnt_d   = cnt_inc;
      end
      S_D_PULSE: begin
        if (!en_progra)     state_d = S_IDLE;
        else if (pulse_end) state_d = S_D_GAP;
        else                cnt_d   = cnt_inc;
      end
      S_D_GAP: begin
        if (!en_progra) begin
          state_d = S_IDLE;
        end else if (!gap_end) begin
          cnt_d = cnt_inc;
        end else if (last_byte) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_A_PULSE;
        end
      end
      S_DONE:     state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!en_progra) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) idx_d = '0;
  end

  // Registered outputs decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      a_d      <= 1'b0;
      cs_n     <= 1'b1;
      wr_n     <= 1'b1;
      busy     <= 1'b0;
      band_fin <= 1'b0;
    end else begin
      unique case (state_d)
        S_A_PULSE: begin
          ad_out   <= FIRST_ADDR + {4'd0, idx_d};
          ad_oe    <= 1'b1;
          a_d      <= 1'b0;
          cs_n     <= 1'b0;
          wr_n     <= 1'b0;
          busy     <= 1'b1;
          band_fin <= 1'b0;
        end
        S_A_GAP: begin
          ad_oe    <= 1'b1;
          a_d      <= 1'b0;
          cs_n     <= 1'b1;
          wr_n     <= 1'b1;
          busy     <= 1'b1;
          band_fin <= 1'b0;
        end
        S_D_PULSE: begin
          ad_out   <= buf_q[8*idx_d +: 8];
          ad_oe    <= 1'b1;
          a_d      <= 1'b1;
          cs_n     <= 1'b0;
          wr_n     <= 1'b0;
          busy     <= 1'b1;
          band_fin <= 1'b0;
        end
        S_D_GAP: begin
          ad_oe    <= 1'b1;
          a_d      <= 1'b1;
          cs_n     <= 1'b1;
          wr_n     <= 1'b1;
          busy     <= 1'b1;
          band_fin <= 1'b0;
        end
        S_LATCH, S_DONE: begin
          ad_out   <= '0;
          ad_oe    <= 1'b0;
          a_d      <= 1'b0;
          cs_n     <= 1'b1;
          wr_n     <= 1'b1;
          busy     <= 1'b1;
          band_fin <= (state_d == S_DONE);
        end
        default: begin
          ad_out   <= '0;
          ad_oe    <= 1'b0;
          a_d      <= 1'b0;
          cs_n     <= 1'b1;
          wr_n     <= 1'b1;
          busy     <= 1'b0;
          band_fin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Bench for rtc_write_sequencer: cycle-exact bus trace
// checked against a position-based reference model.
module tb_rtc_write_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en_a  = 1'b0;
  logic        en_b  = 1'b0;
  logic [47:0] data_a = '0;
  logic [15:0] data_b = '0;

  logic [7:0] ad_a, ad_b;
  logic oe_a, ad_sel_a, cs_a, wr_a, rd_a, busy_a, fin_a;
  logic oe_b, ad_sel_b, cs_b, wr_b, rd_b, busy_b, fin_b;

  logic [14:0] obs_a, obs_b;
  localparam logic [14:0] IDLE_V = 15'b0_0_1_1_1_0_0_00000000;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rtc_write_sequencer dut_a (
    .clock(clock), .reset(reset),
    .en_progra(en_a), .reg_data(data_a),
    .ad_out(ad_a), .ad_oe(oe_a), .a_d(ad_sel_a),
    .cs_n(cs_a), .wr_n(wr_a), .rd_n(rd_a),
    .busy(busy_a), .band_fin(fin_a)
  );

  rtc_write_sequencer #(
    .NUM_REGS(2), .FIRST_ADDR(8'hFF),
    .T_PULSE(1), .T_GAP(1)
  ) dut_b (
    .clock(clock), .reset(reset),
    .en_progra(en_b), .reg_data(data_b),
    .ad_out(ad_b), .ad_oe(oe_b), .a_d(ad_sel_b),
    .cs_n(cs_b), .wr_n(wr_b), .rd_n(rd_b),
    .busy(busy_b), .band_fin(fin_b)
  );

  assign obs_a = {oe_a, ad_sel_a, cs_a, wr_a, rd_a,
                  busy_a, fin_a, ad_a};
  assign obs_b = {oe_b, ad_sel_b, cs_b, wr_b, rd_b,
                  busy_b, fin_b, ad_b};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  // Expected bus value k cycles after the LATCH edge
  function automatic void model(
    input int k, input int n, input int tp, input int tg,
    input logic [7:0] first, input logic [127:0] d,
    output logic [14:0] e, output logic [14:0] m);
    int p, total, j, b, r;
    logic [7:0] addr, dat;
    p     = 2 * (tp + tg);
    total = 1 + n * p;
    e     = IDLE_V;
    m     = '1;
    if (k == 0) begin
      e = 15'b0_0_1_1_1_1_0_00000000;
    end else if (k < total) begin
      j    = k - 1;
      b    = j / p;
      r    = j % p;
      addr = 8'(int'(first) + b);
      dat  = d[8*b +: 8];
      if (r < tp)
        e = {7'b1_0_0_0_1_1_0, addr};
      else if (r < tp + tg)
        e = {7'b1_0_1_1_1_1_0, addr};
      else if (r < 2 * tp + tg)
        e = {7'b1_1_0_0_1_1_0, dat};
      else
        e = {7'b1_1_1_1_1_1_0, dat};
    end else if (k == total) begin
      e = 15'b0_0_1_1_1_1_1_00000000;
      m = 15'b1_0_1_1_1_1_1_00000000;
    end
  endfunction

  // One request; optional corrupt / abort / reset at cycle k
  task automatic run_seq(input int sel,
                         input logic [127:0] d,
                         input int corrupt_k,
                         input int abort_k,
                         input int reset_k);
    int n, tp, tg, total, fins;
    bit stopped, rel;
    logic [7:0]  first;
    logic [14:0] e, m, obs;
    if (sel == 0) begin
      n = 6; tp = 4; tg = 2; first = 8'h21;
    end else begin
      n = 2; tp = 1; tg = 1; first = 8'hFF;
    end
    total   = 1 + n * 2 * (tp + tg);
    fins    = 0;
    stopped = 1'b0;
    rel     = 1'b0;
    @(negedge clock);
    if (sel == 0) begin
      data_a = d[47:0]; en_a = 1'b1;
    end else begin
      data_b = d[15:0]; en_b = 1'b1;
    end
    for (int k = 0; k <= total + 3; k++) begin
      @(posedge clock);
      #1;
      obs = (sel == 0) ? obs_a : obs_b;
      if (stopped) begin
        e = IDLE_V; m = '1;
      end else begin
        model(k, n, tp, tg, first, d, e, m);
      end
      chk($sformatf("bus s%0d k%0d", sel, k),
          32'(obs & m), 32'(e & m));
      chk($sformatf("strobe s%0d k%0d", sel, k),
          32'(obs[12] == obs[11]), 32'd1);
      fins += int'(obs[8]);
      @(negedge clock);
      if (rel) begin
        reset = 1'b0; rel = 1'b0;
      end
      if (k == corrupt_k) begin
        if (sel == 0) data_a = '1;
        else          data_b = '1;
      end
      if (k == abort_k || k == reset_k) begin
        if (sel == 0) en_a = 1'b0;
        else          en_b = 1'b0;
        stopped = 1'b1;
      end
      if (k == reset_k) begin
        reset = 1'b1; rel = 1'b1;
      end
    end
    chk($sformatf("fin_count s%0d", sel), 32'(fins),
        (abort_k < 0 && reset_k < 0) ? 32'd1 : 32'd0);
    en_a  = 1'b0;
    en_b  = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    obs = (sel == 0) ? obs_a : obs_b;
    chk($sformatf("idle_after s%0d", sel),
        32'(obs), 32'(IDLE_V));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] SPEC_D =
    128'h16_05_11_17_43_38;

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_a", 32'(obs_a), 32'(IDLE_V));
    chk("reset_b", 32'(obs_b), 32'(IDLE_V));
    reset = 1'b0;

    run_seq(0, SPEC_D, -1, -1, -1);
    repeat (2) @(negedge clock);
    run_seq(0, SPEC_D, -1, -1, -1);

    run_seq(0, rnd128(), 15, -1, -1);
    run_seq(0, rnd128(), -1, 32, -1);
    run_seq(0, rnd128(), -1, -1, 17);
    run_seq(0, rnd128(), -1, -1, -1);
    for (int i = 0; i < 3; i++)
      run_seq(0, rnd128(), -1, -1, -1);

    run_seq(1, rnd128(), -1, -1, -1);
    run_seq(1, rnd128(), 3, -1, -1);
    run_seq(1, rnd128(), -1, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
